dff_set_reset: RTL and testbench

Parameterised WIDTH-bit D flip-flop register: a rising-edge-clocked storage element with asynchronous clear and asynchronous preset. It is the base storage primitive for pipeline and state registers in the datapath. Every other block that needs a resettable or presettable register instantiates it rather than inferring its own.

---
 rtl/dff_set_reset.sv | 33 +++
 tb/tb_dff_set_reset.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dff_set_reset.sv
// WIDTH-bit rising-edge register with asynchronous active-low clear and
// asynchronous active-high preset; clear has priority over preset.
module dff_set_reset #(
  parameter int unsigned     WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] SET_VALUE   = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // Preset is qualified by reset so that releasing reset while set is still
  // held produces a rising edge here and loads SET_VALUE immediately.
  logic set_act;

  always_comb begin
    set_act = set_i & rst_i;
  end

  always_ff @(posedge clk_i or negedge rst_i or posedge set_act) begin
    if (!rst_i) begin
      q_o <= RESET_VALUE;
    end else if (set_act) begin
      q_o <= SET_VALUE;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

// File: tb/tb_dff_set_reset.sv
// Scoreboard bench for dff_set_reset: default 8-bit instance plus a 16-bit
// instance with a non-zero reset value.
module tb_dff_set_reset;

  logic        clk;
  logic        rst, set;
  logic [7:0]  d8, q8;
  logic        rst16, set16;
  logic [15:0] d16, q16;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] val;
    bit          wide;
  } sb_entry_t;

  sb_entry_t sb_q[$];

  dff_set_reset #(.WIDTH(8)) u_dut8 (
    .clk_i (clk),
    .rst_i (rst),
    .set_i (set),
    .d_i   (d8),
    .q_o   (q8)
  );

  dff_set_reset #(.WIDTH(16), .RESET_VALUE(16'h1234)) u_dut16 (
    .clk_i (clk),
    .rst_i (rst16),
    .set_i (set16),
    .d_i   (d16),
    .q_o   (q16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [15:0] val, input bit wide);
    sb_entry_t e;
    e.tag  = tag;
    e.val  = val;
    e.wide = wide;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop();
    sb_entry_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 16'h0001, 16'h0000);
    end else begin
      e = sb_q.pop_front();
      if (e.wide) check(e.tag, q16, e.val);
      else        check(e.tag, {8'h00, q8}, e.val);
    end
  endtask

  initial begin
    logic [7:0] rnd;
    logic [7:0] prev;

    rst = 1'b1; set = 1'b0; d8 = 8'h00;
    rst16 = 1'b1; set16 = 1'b0; d16 = 16'h0000;

    // async reset mid-cycle, between the edges at t=5 and t=15
    #13 rst = 1'b0;
    sb_push("rst_async", 16'h0000, 1'b0);
    #1 sb_pop();
    #2 sb_push("rst_hold_edge", 16'h0000, 1'b0);
    sb_pop();

    // async set mid-cycle, clock keeps running with d=00
    #1 rst = 1'b1; set = 1'b1; d8 = 8'h00;
    sb_push("set_async", 16'h00FF, 1'b0);
    #1 sb_pop();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      sb_push("set_hold", 16'h00FF, 1'b0);
      #1 sb_pop();
    end

    // synchronous load
    @(negedge clk);
    set = 1'b0; d8 = 8'hAA;
    sb_push("load_pre_edge", 16'h00FF, 1'b0);
    #1 sb_pop();
    sb_push("load_aa", 16'h00AA, 1'b0);
    @(posedge clk); #1 sb_pop();
    @(negedge clk);
    d8 = ~q8;
    sb_push("load_inv", 16'h0055, 1'b0);
    @(posedge clk); #1 sb_pop();

    // priority: reset beats set; releasing reset alone exposes set at once
    #1 rst = 1'b0; set = 1'b1;
    sb_push("prio_rst", 16'h0000, 1'b0);
    #1 sb_pop();
    #1 rst = 1'b1;
    sb_push("prio_release", 16'h00FF, 1'b0);
    #0.5 sb_pop();
    @(negedge clk);
    set = 1'b0; d8 = 8'h55;
    sb_push("reload_55", 16'h0055, 1'b0);
    @(posedge clk); #1 sb_pop();

    // one-unit reset pulse mid-cycle during operation
    @(negedge clk);
    d8 = 8'h3C;
    #2 rst = 1'b0;
    sb_push("pulse_rst", 16'h0000, 1'b0);
    #1 sb_pop();
    rst = 1'b1;
    sb_push("pulse_hold", 16'h0000, 1'b0);
    #1 sb_pop();
    sb_push("pulse_reload", 16'h003C, 1'b0);
    @(posedge clk); #1 sb_pop();

    // random loads, also confirming no d->q path between edges
    prev = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rnd = 8'($urandom);
      d8 = rnd;
      sb_push("rand_hold", {8'h00, prev}, 1'b0);
      #1 sb_pop();
      sb_push("rand_load", {8'h00, rnd}, 1'b0);
      @(posedge clk); #1 sb_pop();
      prev = rnd;
    end

    // 16-bit instance with overridden reset value
    @(negedge clk);
    #2 rst16 = 1'b0;
    sb_push("w16_rst", 16'h1234, 1'b1);
    #1 sb_pop();
    rst16 = 1'b1; set16 = 1'b1;
    sb_push("w16_set", 16'hFFFF, 1'b1);
    #1 sb_pop();
    @(negedge clk);
    set16 = 1'b0; d16 = 16'hBEEF;
    sb_push("w16_pre_edge", 16'hFFFF, 1'b1);
    #1 sb_pop();
    sb_push("w16_load", 16'hBEEF, 1'b1);
    @(posedge clk); #1 sb_pop();

    if (sb_q.size() != 0) check("sb_leftover", 16'(sb_q.size()), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule
